// File: rtl/branch_predict_resolve_pkg.sv
// Shared branch encodings and BHT counter states
// for the EX-stage branch resolution unit.
package branch_predict_resolve_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  localparam logic [1:0] BHT_RST = WNT;

  function automatic logic [1:0] bht_next(
    input logic [1:0] cnt,
    input logic       taken
  );
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != ST)
      nxt = cnt + 2'd1;
    else if (!taken && cnt != SNT)
      nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_resolve_branch_cmp.sv
// Conditional-branch comparator: maps funct3
// and operands to outcome and illegal flag.
module branch_cmp
  import branch_predict_resolve_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_taken,
  output logic            o_illegal
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (i_rs1 == i_rs2);
  assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
  assign w_ltu = (i_rs1 < i_rs2);

  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    unique case (i_funct3)
      F3_BEQ:  o_taken = w_eq;
      F3_BNE:  o_taken = !w_eq;
      F3_BLT:  o_taken = w_lt;
      F3_BGE:  o_taken = !w_lt;
      F3_BLTU: o_taken = w_ltu;
      F3_BGEU: o_taken = !w_ltu;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// EX-stage branch resolution: compare, BHT
// predict/train, redirect pulse and statistics.
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             lookup_taken,
  input  logic             res_valid,
  input  logic             res_kill,
  input  logic [XLEN-1:0]  res_pc,
  input  logic [2:0]       res_funct3,
  input  logic [XLEN-1:0]  res_rs1,
  input  logic [XLEN-1:0]  res_rs2,
  input  logic             res_pred_taken,
  input  logic [XLEN-1:0]  res_target,
  output logic             taken_q,
  output logic             mispredict_q,
  output logic [XLEN-1:0]  redirect_pc_q,
  output logic             illegal_q,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       r_bht [BHT_DEPTH];
  logic             r_taken;
  logic             r_mispred;
  logic             r_illegal;
  logic [XLEN-1:0]  r_redirect;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mp_cnt;

  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_rs_idx;
  logic             w_taken;
  logic             w_illegal;
  logic             w_event;
  logic             w_legal;
  logic             w_mispred;
  logic [XLEN-1:0]  w_next_pc;
  logic             w_unused;

  assign w_lk_idx = lookup_pc[IDX_W+1:2];
  assign w_rs_idx = res_pc[IDX_W+1:2];
  assign w_unused = ^{lookup_pc[XLEN-1:IDX_W+2],
                      lookup_pc[1:0]};

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .i_funct3  (res_funct3),
    .i_rs1     (res_rs1),
    .i_rs2     (res_rs2),
    .o_taken   (w_taken),
    .o_illegal (w_illegal)
  );

  assign w_event   = res_valid && !res_kill;
  assign w_legal   = w_event && !w_illegal;
  assign w_mispred = w_legal
                   && (w_taken != res_pred_taken);
  assign w_next_pc = w_taken ? res_target
                   : res_pc + XLEN'(4);

  // Read-before-write: lookup sees the pre-edge counter
  assign lookup_taken = r_bht[w_lk_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        r_bht[i] <= BHT_RST;
    end else if (w_legal) begin
      r_bht[w_rs_idx] <= bht_next(r_bht[w_rs_idx],
                                  w_taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken    <= 1'b0;
      r_mispred  <= 1'b0;
      r_illegal  <= 1'b0;
      r_redirect <= '0;
    end else begin
      r_taken   <= w_event && w_taken;
      r_mispred <= w_mispred;
      r_illegal <= w_event && w_illegal;
      if (w_event)
        r_redirect <= w_next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else begin
      if (w_legal && r_br_cnt != '1)
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (w_mispred && r_mp_cnt != '1)
        r_mp_cnt <= r_mp_cnt + CNT_W'(1);
    end
  end

  assign taken_q       = r_taken;
  assign mispredict_q  = r_mispred;
  assign illegal_q     = r_illegal;
  assign redirect_pc_q = r_redirect;
  assign branch_cnt    = r_br_cnt;
  assign mispred_cnt   = r_mp_cnt;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed self-checking bench for the
// branch resolution unit.
module tb_branch_predict_resolve;
  import branch_predict_resolve_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] lookup_pc;
  logic        lookup_taken;
  logic        res_valid;
  logic        res_kill;
  logic [63:0] res_pc;
  logic [2:0]  res_funct3;
  logic [63:0] res_rs1;
  logic [63:0] res_rs2;
  logic        res_pred_taken;
  logic [63:0] res_target;
  logic        taken_q;
  logic        mispredict_q;
  logic [63:0] redirect_pc_q;
  logic        illegal_q;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  logic        s_lookup_taken;
  logic        s_taken_q;
  logic        s_mispredict_q;
  logic [63:0] s_redirect_pc_q;
  logic        s_illegal_q;
  logic [3:0]  s_branch_cnt;
  logic [3:0]  s_mispred_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  branch_predict_resolve u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lookup_pc      (lookup_pc),
    .lookup_taken   (lookup_taken),
    .res_valid      (res_valid),
    .res_kill       (res_kill),
    .res_pc         (res_pc),
    .res_funct3     (res_funct3),
    .res_rs1        (res_rs1),
    .res_rs2        (res_rs2),
    .res_pred_taken (res_pred_taken),
    .res_target     (res_target),
    .taken_q        (taken_q),
    .mispredict_q   (mispredict_q),
    .redirect_pc_q  (redirect_pc_q),
    .illegal_q      (illegal_q),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  branch_predict_resolve #(.CNT_W(4)) u_sat (
    .clk            (clk),
    .rst_n          (rst_n),
    .lookup_pc      (lookup_pc),
    .lookup_taken   (s_lookup_taken),
    .res_valid      (res_valid),
    .res_kill       (res_kill),
    .res_pc         (res_pc),
    .res_funct3     (res_funct3),
    .res_rs1        (res_rs1),
    .res_rs2        (res_rs2),
    .res_pred_taken (res_pred_taken),
    .res_target     (res_target),
    .taken_q        (s_taken_q),
    .mispredict_q   (s_mispredict_q),
    .redirect_pc_q  (s_redirect_pc_q),
    .illegal_q      (s_illegal_q),
    .branch_cnt     (s_branch_cnt),
    .mispred_cnt    (s_mispred_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [63:0] pc,
                    input logic [2:0]  f3,
                    input logic [63:0] a,
                    input logic [63:0] b,
                    input logic        pred,
                    input logic [63:0] tgt);
    res_valid      = 1'b1;
    res_kill       = 1'b0;
    res_pc         = pc;
    res_funct3     = f3;
    res_rs1        = a;
    res_rs2        = b;
    res_pred_taken = pred;
    res_target     = tgt;
  endtask

  task automatic idle();
    res_valid = 1'b0;
    res_kill  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    lookup_pc = 64'h100;
    idle();
    res_pc = '0;
    res_funct3 = '0;
    res_rs1 = '0;
    res_rs2 = '0;
    res_pred_taken = 1'b0;
    res_target = '0;
    #12;
    chk("rst_lookup", lookup_taken, 0);
    chk("rst_taken", taken_q, 0);
    chk("rst_mispred", mispredict_q, 0);
    chk("rst_redir", redirect_pc_q, 0);
    chk("rst_illegal", illegal_q, 0);
    chk("rst_brcnt", branch_cnt, 0);
    chk("rst_mpcnt", mispred_cnt, 0);
    rst_n = 1'b1;
    tick();

    br(64'h204, F3_BLTU, '1, 64'd1, 1'b0, 64'h300);
    tick();
    chk("bltu_taken", taken_q, 0);
    chk("bltu_mp", mispredict_q, 0);
    chk("bltu_redir", redirect_pc_q, 64'h208);
    br(64'h204, F3_BLT, '1, 64'd1, 1'b0, 64'h300);
    tick();
    chk("blt_taken", taken_q, 1);
    chk("blt_mp", mispredict_q, 1);
    chk("blt_redir", redirect_pc_q, 64'h300);
    chk("blt_brcnt", branch_cnt, 2);
    idle();
    tick();
    chk("idle_taken", taken_q, 0);
    chk("idle_mp", mispredict_q, 0);
    chk("idle_redir", redirect_pc_q, 64'h300);

    lookup_pc = 64'h40;
    #1;
    chk("tr_init", lookup_taken, 0);
    for (int i = 0; i < 4; i++) begin
      br(64'h40, F3_BEQ, 64'd5, 64'd5, 1'b0, 64'h90);
      tick();
      chk("tr_up", lookup_taken, 1);
    end
    for (int i = 0; i < 3; i++) begin
      br(64'h40, F3_BEQ, 64'd1, 64'd2, 1'b1, 64'h90);
      tick();
      chk("tr_dn", lookup_taken, (i == 0) ? 1 : 0);
    end
    chk("tr_brcnt", branch_cnt, 9);
    chk("tr_mpcnt", mispred_cnt, 8);

    br(64'h40, F3_BEQ, 64'd5, 64'd5, 1'b1, 64'h90);
    tick();
    chk("hz_pre", lookup_taken, 0);
    lookup_pc = 64'h80;
    br(64'h80, F3_BEQ, 64'd7, 64'd7, 1'b1, 64'h180);
    #1;
    chk("hz_same", lookup_taken, 0);
    tick();
    chk("hz_next", lookup_taken, 1);
    chk("hz_mp", mispredict_q, 0);

    br(64'h80, F3_BLT, '1, 64'd1, 1'b0, 64'h500);
    res_kill = 1'b1;
    tick();
    chk("kill_mp", mispredict_q, 0);
    chk("kill_taken", taken_q, 0);
    chk("kill_redir", redirect_pc_q, 64'h180);
    chk("kill_brcnt", branch_cnt, 11);
    chk("kill_bht", lookup_taken, 1);

    br(64'h80, 3'b010, 64'd1, 64'd1, 1'b1, 64'h500);
    tick();
    chk("ill_q", illegal_q, 1);
    chk("ill_mp", mispredict_q, 0);
    chk("ill_taken", taken_q, 0);
    chk("ill_redir", redirect_pc_q, 64'h84);
    chk("ill_brcnt", branch_cnt, 11);
    chk("ill_mpcnt", mispred_cnt, 8);
    chk("ill_bht", lookup_taken, 1);
    idle();
    tick();
    chk("ill_clr", illegal_q, 0);

    br(64'h10, F3_BGE, '1, 64'd1, 1'b0, 64'h600);
    tick();
    chk("bge_taken", taken_q, 0);
    br(64'h10, F3_BGEU, '1, 64'd1, 1'b0, 64'h600);
    tick();
    chk("bgeu_taken", taken_q, 1);
    chk("bgeu_mp", mispredict_q, 1);
    br(64'h10, F3_BNE, 64'd3, 64'd3, 1'b0, 64'h600);
    tick();
    chk("bne_taken", taken_q, 0);
    chk("bne_redir", redirect_pc_q, 64'h14);
    chk("cmp_brcnt", branch_cnt, 14);
    chk("cmp_mpcnt", mispred_cnt, 9);

    for (int i = 0; i < 20; i++) begin
      br(64'h10, F3_BLT, '1, 64'd1, 1'b0, 64'h700);
      tick();
    end
    chk("sat_mpcnt", s_mispred_cnt, 15);
    chk("sat_brcnt", s_branch_cnt, 15);
    chk("big_mpcnt", mispred_cnt, 29);
    chk("big_brcnt", branch_cnt, 34);
    chk("pulse_on", mispredict_q, 1);

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mp", mispredict_q, 0);
    chk("arst_brcnt", branch_cnt, 0);
    lookup_pc = 64'h80;
    #1;
    chk("arst_bht", lookup_taken, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
